seg_scan_mux: RTL and testbench

- Display back-end directly downstream of the microprocessor core.
- Consumes the core's per-field 7-segment patterns (programcounter/instruction/data, one and sixteen digits) and its branch flag.
- Time-multiplexes them onto the board's 4-digit common-anode display in three pages: PC, instruction, data.
- Runs on the same clk_in as the core; inputs are snapshotted once per scan so a digit never tears mid-refresh.

---
 rtl/seg_scan_mux.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Scans the core's PC / instruction / data 7-segment patterns onto a 4-digit
// common-anode display, one page at a time, with a stretched branch indicator.
module seg_scan_mux #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned PAGE_DWELL = 250,
    parameter int unsigned BR_STRETCH = 100
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [6:0] programcounter_one,
    input  logic [6:0] programcounter_sixteen,
    input  logic [6:0] instruction_one,
    input  logic [6:0] instruction_sixteen,
    input  logic [6:0] data_one,
    input  logic [6:0] data_sixteen,
    input  logic       branch,
    input  logic       page_hold,
    input  logic       page_next,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] page,
    output logic       branch_led
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = $clog2(PAGE_DWELL + 1);
    localparam int unsigned BW = $clog2(BR_STRETCH + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_TAG_P = 7'b0001100;
    localparam logic [6:0] SEG_TAG_I = 7'b1001111;
    localparam logic [6:0] SEG_TAG_D = 7'b0100001;

    typedef enum logic [1:0] {
        PG_PC    = 2'd0,
        PG_INSTR = 2'd1,
        PG_DATA  = 2'd2,
        PG_BAD   = 2'd3
    } page_e;

    // Snapshot slots: 0/1 PC one/sixteen, 2/3 instruction, 4/5 data
    logic [5:0][6:0] snap_q, snap_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] br_cnt_q, br_cnt_d;
    page_e         page_q, page_d;
    logic          pn_q;
    logic          led_q, led_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick_c, scan_done_c, pn_rise_c, auto_adv_c, adv_c;
    logic [6:0]    sel_one_c, sel_sixteen_c, tag_c;

    // Scan timing
    always_comb begin
        tick_c      = (presc_q == PW'(SCAN_DIV - 1));
        scan_done_c = tick_c && (digit_q == 2'd3);
        presc_d     = tick_c ? '0 : presc_q + PW'(1);
        digit_d     = tick_c ? digit_q + 2'd1 : digit_q;
    end

    // Page advance requests
    always_comb begin
        pn_rise_c  = page_next && !pn_q;
        auto_adv_c = scan_done_c && (dwell_q == DW'(PAGE_DWELL - 1)) && !page_hold;
        adv_c      = pn_rise_c || auto_adv_c;
    end

    // Page FSM: state register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            page_q <= PG_PC;
        end else begin
            page_q <= page_d;
        end
    end

    // Page FSM: next state; a manual edge and an auto advance together move one page
    always_comb begin
        page_d = page_q;
        case (page_q)
            PG_PC:    if (adv_c) page_d = PG_INSTR;
            PG_INSTR: if (adv_c) page_d = PG_DATA;
            PG_DATA:  if (adv_c) page_d = PG_PC;
            default:  page_d = PG_PC;
        endcase
    end

    // Page FSM: content select, taken from the page being entered so a new
    // scan started on the same edge as a page change shows a single page
    always_comb begin
        sel_one_c     = snap_d[0];
        sel_sixteen_c = snap_d[1];
        tag_c         = SEG_TAG_P;
        case (page_d)
            PG_INSTR: begin
                sel_one_c     = snap_d[2];
                sel_sixteen_c = snap_d[3];
                tag_c         = SEG_TAG_I;
            end
            PG_DATA: begin
                sel_one_c     = snap_d[4];
                sel_sixteen_c = snap_d[5];
                tag_c         = SEG_TAG_D;
            end
            default: begin
                sel_one_c     = snap_d[0];
                sel_sixteen_c = snap_d[1];
                tag_c         = SEG_TAG_P;
            end
        endcase
    end

    // Dwell counter saturates while held so auto advance fires on the first scan after release
    always_comb begin
        dwell_d = dwell_q;
        if (page_d != page_q) begin
            dwell_d = '0;
        end else if (scan_done_c && (dwell_q != DW'(PAGE_DWELL - 1))) begin
            dwell_d = dwell_q + DW'(1);
        end
    end

    // Snapshot capture once per scan
    always_comb begin
        snap_d = snap_q;
        if (scan_done_c) begin
            snap_d = {data_sixteen, data_one,
                      instruction_sixteen, instruction_one,
                      programcounter_sixteen, programcounter_one};
        end
    end

    // Branch stretcher: a live branch reload wins over the scan decrement
    always_comb begin
        br_cnt_d = br_cnt_q;
        led_d    = led_q;
        if (branch) begin
            br_cnt_d = BW'(BR_STRETCH);
            led_d    = 1'b1;
        end else if (scan_done_c && (br_cnt_q != '0)) begin
            br_cnt_d = br_cnt_q - BW'(1);
            if (br_cnt_q == BW'(1)) begin
                led_d = 1'b0;
            end
        end
    end

    // Display drive; dp follows the stretched branch while digit 0 is lit
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (tick_c) begin
            an_d = ~(4'b0001 << digit_d);
            case (digit_d)
                2'd0:    seg_d = sel_one_c;
                2'd1:    seg_d = sel_sixteen_c;
                2'd2:    seg_d = SEG_BLANK;
                default: seg_d = tag_c;
            endcase
        end
        dp_d = ~(~an_d[0] & led_d);
    end

    // Datapath registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            presc_q  <= '0;
            digit_q  <= '0;
            dwell_q  <= '0;
            br_cnt_q <= '0;
            pn_q     <= 1'b0;
            led_q    <= 1'b0;
            snap_q   <= '1;
            an_q     <= 4'hF;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            digit_q  <= digit_d;
            dwell_q  <= dwell_d;
            br_cnt_q <= br_cnt_d;
            pn_q     <= page_next;
            led_q    <= led_d;
            snap_q   <= snap_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign page       = page_q;
    assign branch_led = led_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with SCAN_DIV=4, PAGE_DWELL=2, BR_STRETCH=3.
// Edge numbers count clk_in rising edges after the initial reset release.
module tb_seg_scan_mux;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [6:0] programcounter_one, programcounter_sixteen;
    logic [6:0] instruction_one, instruction_sixteen;
    logic [6:0] data_one, data_sixteen;
    logic       branch, page_hold, page_next;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] page;
    logic       branch_led;

    int e      = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    seg_scan_mux #(
        .SCAN_DIV  (4),
        .PAGE_DWELL(2),
        .BR_STRETCH(3)
    ) dut (
        .clk_in                (clk_in),
        .reset                 (reset),
        .programcounter_one    (programcounter_one),
        .programcounter_sixteen(programcounter_sixteen),
        .instruction_one       (instruction_one),
        .instruction_sixteen   (instruction_sixteen),
        .data_one              (data_one),
        .data_sixteen          (data_sixteen),
        .branch                (branch),
        .page_hold             (page_hold),
        .page_next             (page_next),
        .an                    (an),
        .seg                   (seg),
        .dp                    (dp),
        .page                  (page),
        .branch_led            (branch_led)
    );

    always #10 clk_in = ~clk_in;

    // Advance to 1 ns after edge j
    task automatic go(input int j);
        while (e < j) begin
            @(posedge clk_in);
            e++;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, obs, exp);
        end
    endtask

    initial begin
        reset                  = 1'b1;
        branch                 = 1'b0;
        page_hold              = 1'b0;
        page_next              = 1'b0;
        programcounter_one     = 7'h40;
        programcounter_sixteen = 7'h79;
        instruction_one        = 7'h24;
        instruction_sixteen    = 7'h30;
        data_one               = 7'h19;
        data_sixteen           = 7'h12;

        repeat (5) @(posedge clk_in);
        #1;
        chk("rst_an",   8'(an),         8'h0F);
        chk("rst_seg",  8'(seg),        8'h7F);
        chk("rst_dp",   8'(dp),         8'h01);
        chk("rst_page", 8'(page),       8'h00);
        chk("rst_led",  8'(branch_led), 8'h00);
        reset = 1'b0;
        e     = 0;

        // First scan: blank until the first tick, digit 1 from empty snapshot
        go(3);   chk("pre_tick_an", 8'(an), 8'h0F);  chk("pre_tick_seg", 8'(seg), 8'h7F);
        go(4);   chk("tick1_an", 8'(an), 8'h0D);     chk("tick1_seg", 8'(seg), 8'h7F);
        go(12);  chk("tag_p0", 8'(seg), 8'h0C);      chk("an_d3", 8'(an), 8'h07);

        // After first scan_done: PC page content
        go(16);  chk("pc_one", 8'(seg), 8'h40);      chk("an_d0", 8'(an), 8'h0E);
                 chk("page0", 8'(page), 8'h00);
        go(20);  chk("pc_sixteen", 8'(seg), 8'h79);  chk("an_d1", 8'(an), 8'h0D);
        go(24);  chk("blank_d2", 8'(seg), 8'h7F);    chk("an_d2", 8'(an), 8'h0B);
        go(28);  chk("tag_p", 8'(seg), 8'h0C);       chk("an_d3b", 8'(an), 8'h07);

        // Auto page sequence
        go(31);  chk("page0_hold", 8'(page), 8'h00);
        go(32);  chk("page1", 8'(page), 8'h01);      chk("instr_one", 8'(seg), 8'h24);
        go(36);  chk("instr_sixteen", 8'(seg), 8'h30);
        go(44);  chk("tag_i", 8'(seg), 8'h4F);
        go(64);  chk("page2", 8'(page), 8'h02);      chk("data_one", 8'(seg), 8'h19);

        // Mid-scan input change must not tear
        go(66);  data_one = 7'h02;
        go(67);  chk("no_tear_d0", 8'(seg), 8'h19);
        go(68);  chk("data_sixteen", 8'(seg), 8'h12);
        go(76);  chk("tag_d", 8'(seg), 8'h21);
        go(80);  chk("new_data_one", 8'(seg), 8'h02); chk("page2_b", 8'(page), 8'h02);
        go(96);  chk("page_wrap", 8'(page), 8'h00);   chk("wrap_seg", 8'(seg), 8'h40);

        // Hold freezes auto advance
        go(97);  page_hold = 1'b1;
        go(128); chk("hold_128", 8'(page), 8'h00);
        go(176); chk("hold_176", 8'(page), 8'h00);
        go(177); page_hold = 1'b0;
        go(191); chk("pre_release_adv", 8'(page), 8'h00);
        go(192); chk("release_adv", 8'(page), 8'h01);

        // Manual advance during hold, mid digit-0 slot, with dwell at 1
        go(193); page_hold = 1'b1;
        go(208); chk("pre_manual", 8'(page), 8'h01); chk("pre_manual_seg", 8'(seg), 8'h24);
                 page_next = 1'b1;
        go(209); chk("manual_adv", 8'(page), 8'h02); chk("no_redraw", 8'(seg), 8'h24);
                 page_hold = 1'b0;
        go(210); page_next = 1'b0;
        go(212); chk("manual_d1", 8'(seg), 8'h12);
        go(224); chk("dwell_cleared", 8'(page), 8'h02);
        go(240); chk("after_manual_auto", 8'(page), 8'h00);

        // Branch stretcher and dp
        go(241); branch = 1'b1;
        go(242); branch = 1'b0;
                 chk("led_set", 8'(branch_led), 8'h01); chk("dp_d0_lit", 8'(dp), 8'h00);
        go(244); chk("dp_d1", 8'(dp), 8'h01);           chk("led_244", 8'(branch_led), 8'h01);
        go(256); chk("dp_d0_256", 8'(dp), 8'h00);
        go(265); branch = 1'b1;
        go(266); branch = 1'b0;
        go(287); chk("led_287", 8'(branch_led), 8'h01);
        go(288); chk("led_restart", 8'(branch_led), 8'h01); chk("dp_288", 8'(dp), 8'h00);
        go(303); chk("led_303", 8'(branch_led), 8'h01);
        go(304); chk("led_clear", 8'(branch_led), 8'h00);   chk("dp_clear", 8'(dp), 8'h01);

        // Manual edge coincident with auto advance
        go(335); chk("pre_coincide", 8'(page), 8'h02);
                 page_next = 1'b1;
        go(336); chk("coincide_one_step", 8'(page), 8'h00);
        go(337); chk("coincide_settled", 8'(page), 8'h00);
                 page_next = 1'b0;

        // Reset mid-operation
        go(369); branch = 1'b1;
        go(370); branch = 1'b0;
                 chk("pre_rst_page", 8'(page), 8'h01); chk("pre_rst_dp", 8'(dp), 8'h00);
                 chk("pre_rst_an", 8'(an), 8'h0E);
        go(371); reset = 1'b1;
        go(372); chk("mid_rst_an", 8'(an), 8'h0F);    chk("mid_rst_seg", 8'(seg), 8'h7F);
                 chk("mid_rst_dp", 8'(dp), 8'h01);    chk("mid_rst_page", 8'(page), 8'h00);
                 chk("mid_rst_led", 8'(branch_led), 8'h00);
        go(373); reset = 1'b0;
        go(376); chk("rerun_pre_tick", 8'(an), 8'h0F);
        go(377); chk("rerun_tick_an", 8'(an), 8'h0D); chk("rerun_snap_blank", 8'(seg), 8'h7F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
